// File: rtl/ps2_scancode_decoder_if.sv
// Event stream from the scan-code decoder to its consumer: head entry plus valid/ready handshake.
interface ps2_scancode_decoder_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       out_ext;
  logic       out_release;

  modport master (output out_valid, output out_code, output out_ext, output out_release,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_code, input  out_ext, input  out_release,
                  output out_ready);
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: synchronises byte-valid, folds E0/F0/E1 prefixes into events, buffers them in a FIFO.
// Latency: push two clk edges after ps2_valid is first captured; full FIFO without pop drops the event and sets overflow.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  ps2_valid,
  input  logic [7:0]            ps2_data,
  ps2_scancode_decoder_if.master evt,
  output logic                  overflow,
  input  logic                  ovf_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE_SKIP} state_t;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } evt_t;

  state_t      state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic        sync1_q, sync2_q, edge_q;
  logic        byte_stb;
  logic        push;
  evt_t        push_evt;

  evt_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] cnt_q;
  logic        ovf_q;
  logic        full, pop, push_ok;
  evt_t        head;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= ps2_valid;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign byte_stb = sync2_q & ~edge_q;

  function automatic logic is_filtered(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      skip_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Pause sequences and filtered bytes override whatever prefix is pending.
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    push     = 1'b0;
    push_evt = '{code: ps2_data, ext: 1'b0, rel: 1'b0};
    if (byte_stb) begin
      if (state_q == PAUSE_SKIP) begin
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) begin
          push          = 1'b1;
          push_evt.code = 8'hE1;
          state_d       = IDLE;
        end
      end else if (ps2_data == 8'hE1) begin
        state_d = PAUSE_SKIP;
        skip_d  = 3'd7;
      end else if (is_filtered(ps2_data)) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (ps2_data == 8'hF0)      state_d = GOT_F0;
            else if (ps2_data == 8'hE0) state_d = GOT_E0;
            else                        push = 1'b1;
          end
          GOT_E0: begin
            if (ps2_data == 8'hF0)      state_d = GOT_E0F0;
            else if (ps2_data != 8'hE0) begin
              push         = 1'b1;
              push_evt.ext = 1'b1;
              state_d      = IDLE;
            end
          end
          GOT_F0: begin
            if (ps2_data != 8'hF0) begin
              push         = 1'b1;
              push_evt.rel = 1'b1;
              state_d      = IDLE;
            end
          end
          GOT_E0F0: begin
            if (ps2_data != 8'hF0) begin
              push         = 1'b1;
              push_evt.ext = 1'b1;
              push_evt.rel = 1'b1;
              state_d      = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign full    = (cnt_q == FULL_CNT);
  assign pop     = evt.out_valid & evt.out_ready;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_evt;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      // Set wins over a simultaneous clear.
      if (push & full & ~pop) ovf_q <= 1'b1;
      else if (ovf_clr)       ovf_q <= 1'b0;
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign evt.out_valid   = (cnt_q != '0);
  assign evt.out_code    = evt.out_valid ? head.code : 8'h00;
  assign evt.out_ext     = evt.out_valid & head.ext;
  assign evt.out_release = evt.out_valid & head.rel;
  assign overflow        = ovf_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised and directed bench for ps2_scancode_decoder against a byte-level decode model and an event queue.
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ev_t;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       ps2_valid = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  ps2_scancode_decoder_if bus ();

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .areset    (areset),
    .ps2_valid (ps2_valid),
    .ps2_data  (ps2_data),
    .evt       (bus),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending prefix flags, a pause byte budget, and a plain event queue.
  ev_t mq[$];
  bit  m_ovf;
  bit  h1, h2, h3;
  int  skip_left;
  bit  ext_p, rel_p;

  function automatic bit filtered(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  task automatic decode(input logic [7:0] b, output bit have, output ev_t e);
    have = 1'b0;
    e    = '{code: b, ext: 1'b0, rel: 1'b0};
    if (skip_left > 0) begin
      skip_left--;
      if (skip_left == 0) begin
        have   = 1'b1;
        e.code = 8'hE1;
      end
    end else if (b == 8'hE1) begin
      skip_left = 7; ext_p = 0; rel_p = 0;
    end else if (filtered(b)) begin
      ext_p = 0; rel_p = 0;
    end else if (b == 8'hF0) begin
      rel_p = 1;
    end else if (b == 8'hE0 && !rel_p) begin
      ext_p = 1;
    end else begin
      have = 1'b1; e.ext = ext_p; e.rel = rel_p;
      ext_p = 0; rel_p = 0;
    end
  endtask

  always @(posedge clk) begin
    bit  act, pop, have, set;
    int  pre;
    ev_t e;
    if (areset) begin
      mq.delete();
      m_ovf = 0; h1 = 0; h2 = 0; h3 = 0;
      skip_left = 0; ext_p = 0; rel_p = 0;
    end else begin
      // A rising ps2_valid captured at edge N is acted on at edge N+2.
      act  = h2 && !h3;
      pre  = mq.size();
      pop  = (pre > 0) && bus.out_ready;
      have = 0;
      set  = 0;
      if (act) decode(ps2_data, have, e);
      if (pop) void'(mq.pop_front());
      if (have) begin
        if (pre < DEPTH || pop) mq.push_back(e);
        else set = 1;
      end
      if (set) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      h3 = h2; h2 = h1; h1 = ps2_valid;
    end
  end

  always @(negedge clk) begin
    if (areset) begin
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_out_code", 32'(bus.out_code), 32'd0);
      chk("rst_out_ext", 32'(bus.out_ext), 32'd0);
      chk("rst_out_release", 32'(bus.out_release), 32'd0);
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() > 0) begin
        chk("out_code", 32'(bus.out_code), 32'(mq[0].code));
        chk("out_ext", 32'(bus.out_ext), 32'(mq[0].ext));
        chk("out_release", 32'(bus.out_release), 32'(mq[0].rel));
      end
    end
  end

  // Log of accepted events, used by the literal directed expectations.
  ev_t got[$];
  ev_t exp_q[$];
  always @(posedge clk) begin
    if (!areset && bus.out_valid && bus.out_ready)
      got.push_back('{code: bus.out_code, ext: bus.out_ext, rel: bus.out_release});
  end

  task automatic cmp_log(input string name);
    chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({name, "_event"}, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  function automatic ev_t mk(input logic [7:0] c, input logic x, input logic r);
    return '{code: c, ext: x, rel: r};
  endfunction

  bit rnd = 0;
  int rdy_pct = 50;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rnd) begin
        bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
        ovf_clr = ($urandom_range(0, 29) == 0);
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int hi, input int lo);
    ps2_data  = b;
    ps2_valid = 1'b1;
    tick(hi);
    ps2_valid = 1'b0;
    tick(lo);
  endtask

  task automatic send_list(input logic [7:0] bs[$]);
    foreach (bs[i]) send(bs[i], 3, 2);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    tick(3);
    areset = 1'b0;
    tick(2);

    // First-byte latency with the consumer stalled.
    ps2_data = 8'h1C; ps2_valid = 1'b1;
    tick(1);
    chk("lat_edge_n", 32'(bus.out_valid), 32'd0);
    tick(1);
    chk("lat_edge_n1", 32'(bus.out_valid), 32'd0);
    tick(1);
    chk("lat_edge_n2", 32'(bus.out_valid), 32'd1);
    chk("lat_code", 32'(bus.out_code), 32'h1C);
    ps2_valid = 1'b0;
    tick(2);
    bus.out_ready = 1'b1;
    tick(3);
    exp_q.push_back(mk(8'h1C, 0, 0));
    cmp_log("latency");

    send_list('{8'h1C, 8'hF0, 8'h1C});
    tick(3);
    exp_q.push_back(mk(8'h1C, 0, 0));
    exp_q.push_back(mk(8'h1C, 0, 1));
    cmp_log("make_break");

    send_list('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hAA, 8'hFA});
    tick(3);
    exp_q.push_back(mk(8'h75, 1, 0));
    exp_q.push_back(mk(8'h75, 1, 1));
    cmp_log("extended_filtered");

    send_list('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0});
    tick(3);
    chk("pause_early", 32'(got.size()), 32'd0);
    send_list('{8'h77, 8'h1C});
    tick(3);
    exp_q.push_back(mk(8'hE1, 0, 0));
    exp_q.push_back(mk(8'h1C, 0, 0));
    cmp_log("pause");

    // Five makes into a stalled 4-deep FIFO.
    bus.out_ready = 1'b0;
    send_list('{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C});
    chk("ovf_set", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    bus.out_ready = 1'b1;
    tick(8);
    exp_q.push_back(mk(8'h15, 0, 0));
    exp_q.push_back(mk(8'h1D, 0, 0));
    exp_q.push_back(mk(8'h24, 0, 0));
    exp_q.push_back(mk(8'h2D, 0, 0));
    cmp_log("overflow_drop");

    // Full FIFO, pop coinciding with the push edge.
    bus.out_ready = 1'b0;
    send_list('{8'h15, 8'h1D, 8'h24, 8'h2D});
    ps2_data = 8'h2C; ps2_valid = 1'b1;
    tick(2);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    chk("full_pop_push_ovf", 32'(overflow), 32'd0);
    chk("full_pop_push_head", 32'(bus.out_code), 32'h1D);
    ps2_valid = 1'b0;
    tick(2);
    bus.out_ready = 1'b1;
    tick(8);
    exp_q.push_back(mk(8'h15, 0, 0));
    exp_q.push_back(mk(8'h1D, 0, 0));
    exp_q.push_back(mk(8'h24, 0, 0));
    exp_q.push_back(mk(8'h2D, 0, 0));
    exp_q.push_back(mk(8'h2C, 0, 0));
    cmp_log("full_pop_push");

    // Reset mid-prefix with a full FIFO and overflow set.
    bus.out_ready = 1'b0;
    send_list('{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'hE0});
    chk("pre_reset_ovf", 32'(overflow), 32'd1);
    areset = 1'b1;
    tick(2);
    areset = 1'b0;
    tick(2);
    got.delete();
    bus.out_ready = 1'b1;
    send(8'h75, 3, 2);
    tick(3);
    exp_q.push_back(mk(8'h75, 0, 0));
    cmp_log("reset_prefix");

    // ps2_valid held high across reset release yields exactly one byte.
    ps2_data = 8'h1C; ps2_valid = 1'b1;
    tick(1);
    areset = 1'b1;
    tick(2);
    areset = 1'b0;
    tick(4);
    ps2_valid = 1'b0;
    tick(4);
    exp_q.push_back(mk(8'h1C, 0, 0));
    cmp_log("valid_across_reset");

    // Randomised traffic checked cycle by cycle against the model.
    rnd = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] b;
      if (i % 100 == 0) rdy_pct = $urandom_range(10, 95);
      r = $urandom_range(0, 15);
      if (r < 3)       b = 8'hE0;
      else if (r < 5)  b = 8'hF0;
      else if (r == 5) b = 8'hE1;
      else if (r == 6) b = 8'hAA;
      else if (r == 7) b = 8'hFA;
      else             b = 8'($urandom_range(0, 255));
      send(b, $urandom_range(3, 6), $urandom_range(2, 5));
      if (i == 217) begin
        areset = 1'b1;
        tick(2);
        areset = 1'b0;
        tick(1);
      end
    end
    rnd = 0;
    bus.out_ready = 1'b1;
    ovf_clr = 1'b0;
    tick(10);
    chk("final_drained", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
